// File: rtl/alu_div_pkg.sv
// rtl/alu_div_pkg.sv - shared types and helpers for the sequential divider
package alu_div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

    localparam int DIV_WIDTH = 32;

    // Negation is done at a fixed wide width; truncating the result to any
    // narrower WIDTH gives the same value as negating mod 2**WIDTH.
    localparam int NEG_W = 64;

    function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] v);
        return ~v + NEG_W'(1);
    endfunction

endpackage

// File: rtl/alu_trial_sub.sv
// rtl/alu_trial_sub.sv - WIDTH+1-bit trial subtractor, carry-select over 4-bit ripple blocks
module alu_trial_sub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           sign
);

    // Always at least one pad bit above the result so the slices below stay valid.
    localparam int NB = (WIDTH + 1) / 4 + 1;
    localparam int PW = NB * 4;

    logic [PW-1:0] ap;
    logic [PW-1:0] bn;
    logic [PW-1:0] sum;
    logic [NB:0]   carry;

    assign ap       = PW'(a);
    assign bn       = ~(PW'(b));
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [3:0] xa;
        logic [3:0] xb;
        logic [3:0] s0;
        logic [3:0] s1;
        logic       co0;
        logic       co1;

        assign xa = ap[4*g +: 4];
        assign xb = bn[4*g +: 4];

        // Ripple both carry-in hypotheses through this block.
        always_comb begin
            logic k0;
            logic k1;
            k0 = 1'b0;
            k1 = 1'b1;
            s0 = '0;
            s1 = '0;
            for (int i = 0; i < 4; i++) begin
                s0[i] = xa[i] ^ xb[i] ^ k0;
                k0    = (xa[i] & xb[i]) | (k0 & (xa[i] ^ xb[i]));
                s1[i] = xa[i] ^ xb[i] ^ k1;
                k1    = (xa[i] & xb[i]) | (k1 & (xa[i] ^ xb[i]));
            end
            co0 = k0;
            co1 = k1;
        end

        assign sum[4*g +: 4] = carry[g] ? s1 : s0;
        assign carry[g+1]    = carry[g] ? co1 : co0;
    end

    assign diff = sum[WIDTH:0];
    assign sign = sum[WIDTH];

    logic unused_pad;
    assign unused_pad = ^{carry[NB], sum[PW-1:WIDTH+1]};

endmodule

// File: rtl/alu_seq_divider.sv
// rtl/alu_seq_divider.sv - multi-cycle restoring signed/unsigned divider with start/done handshake
module alu_seq_divider
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return WIDTH'(twos_neg(NEG_W'(v)));
    endfunction

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    // Partial remainder. It stays below the divisor between iterations, so the
    // WIDTH+1-bit trial value never needs its top bit kept.
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;     // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] d;
    logic             neg_q;
    logic             neg_r;
    logic             dz_pend;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   r_prime;
    logic [WIDTH:0]   trial_diff;
    logic             trial_sign;

    assign a_neg   = is_signed & dividend[WIDTH-1];
    assign b_neg   = is_signed & divisor[WIDTH-1];
    assign a_mag   = a_neg ? neg_w(dividend) : dividend;
    assign b_mag   = b_neg ? neg_w(divisor) : divisor;
    assign r_prime = {r, q[WIDTH-1]};

    alu_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
        .a    (r_prime),
        .b    ({1'b0, d}),
        .diff (trial_diff),
        .sign (trial_sign)
    );

    logic unused_msbs;
    assign unused_msbs = ^{r_prime[WIDTH], trial_diff[WIDTH]};

    // Control FSM with the datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_pend     <= 1'b0;
            ready       <= 1'b1;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ready       <= 1'b0;
                        div_by_zero <= 1'b0;
                        cnt         <= '0;
                        d           <= b_mag;
                        if (divisor == '0) begin
                            // Preload the fixed results; FIX passes them through unchanged.
                            q       <= '1;
                            r       <= dividend;
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
                            dz_pend <= 1'b1;
                            state   <= FIX;
                        end else begin
                            q       <= a_mag;
                            r       <= '0;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            dz_pend <= 1'b0;
                            state   <= CALC;
                        end
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    r   <= trial_sign ? r_prime[WIDTH-1:0] : trial_diff[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], ~trial_sign};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient    <= neg_q ? neg_w(q) : q;
                    remainder   <= neg_r ? neg_w(r) : r;
                    div_by_zero <= dz_pend;
                    done        <= 1'b1;
                    ready       <= 1'b1;
                    state       <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_divider.sv
// tb/tb_alu_seq_divider.sv - scoreboard bench for alu_seq_divider
module tb_alu_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ready;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t sb[$];

    alu_seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb_;
        e.start_cyc = 0;
        if (b == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 2;
        end else begin
            if (sgn) begin
                sa  = longint'($signed(a));
                sb_ = longint'($signed(b));
            end else begin
                sa  = longint'({32'd0, a});
                sb_ = longint'({32'd0, b});
            end
            e.q   = 32'(sa / sb_);
            e.r   = 32'(sa % sb_);
            e.dz  = 1'b0;
            e.lat = 34;
        end
        return e;
    endfunction

    // Compare every done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", div_by_zero, e.dz);
                check("latency", 64'(cycle - e.start_cyc + 1), 64'(e.lat));
                check("ready_at_done", ready, 1'b1);
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
        check("ready_wait", ready, 1'b1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        check("done_wait", done, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic drive_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        wait_ready();
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        e = model(sgn, a, b);
        e.start_cyc = cycle + 1;
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    initial begin
        exp_t prev;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dz", div_by_zero, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        drive_op(1'b0, 32'd100, 32'd7);
        check("busy_ready", ready, 1'b0);
        drain();
        drive_op(1'b1, 32'hFFFF_FF9C, 32'd7);
        drive_op(1'b0, 32'hFFFF_FFFF, 32'd1);
        drive_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        drive_op(1'b0, 32'h0000_1234, 32'd0);
        drive_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        drive_op(1'b1, 32'hFFFF_FF9C, 32'd0);
        drain();

        // Start while busy must not disturb the division in flight.
        drive_op(1'b0, 32'd1000, 32'd3);
        repeat (3) @(negedge clk);
        check("busy_ignore_ready", ready, 1'b0);
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'd5;
        divisor   = 32'd0;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset mid-operation aborts with no done.
        wait_ready();
        is_signed = 1'b0;
        dividend  = 32'd12345;
        divisor   = 32'd11;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", ready, 1'b1);
        check("abort_done", done, 1'b0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_dz", div_by_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        drive_op(1'b1, 32'hFFFF_FC18, 32'd9);
        drain();

        // Back-to-back: new start accepted in the DONE cycle, old results held.
        prev = model(1'b0, 32'd999, 32'd10);
        drive_op(1'b0, 32'd999, 32'd10);
        wait_done();
        drive_op(1'b1, 32'h8000_0001, 32'd4);
        check("b2b_accepted", ready, 1'b0);
        repeat (5) @(negedge clk);
        check("b2b_hold_q", quotient, prev.q);
        check("b2b_hold_r", remainder, prev.r);
        drain();

        for (int k = 0; k < 8; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
            drive_op(1'($urandom_range(0, 1)), a, b);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
